// File: rtl/usb_fs_tx.sv
// usb_fs_tx -- device-side USB 2.0 full-speed serial transmitter.
//
// Takes a packet as a byte stream (PID first, then payload/CRC supplied
// upstream). It drives SYNC, the NRZI-encoded bit-stuffed data, then EOP
// (SE0 SE0 J) on D+/D-.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   tx_data      byte to transmit, LSB first
//   tx_valid     tx_data valid; starts a packet when idle
//   tx_last      tx_data is the final byte of the packet
//   tx_ready     pulse: tx_data/tx_last consumed this cycle
//   tx_underrun  pulse: tx_valid was low when a byte was needed
//   busy         high from packet start until the EOP J completes
//   dp_tx/dn_tx  line drive values (J = 1/0, K = 0/1, SE0 = 0/0)
//   tx_oe        line output enable
module usb_fs_tx #(
    parameter int CLK_PER_BIT  = 4,
    parameter int STUFF_BITS_N = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       busy,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oe
);

    localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_BITS_N + 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic [2:0]      idx_reg;     // sync bit / data bit / EOP SE0 index
    logic [7:0]      shift_reg;
    logic            last_reg;
    logic [OW-1:0]   ones_reg;
    logic            level_reg;   // current NRZI level, 1 = J

    logic            bit_end;
    logic            stuff_due;
    logic            handoff;
    logic [2:0]      idx_inc;
    logic            data_bit;
    logic            next_level;
    logic [OW-1:0]   ones_next;

    assign bit_end   = (timer_reg == TW'(CLK_PER_BIT - 1));
    assign stuff_due = (ones_reg == OW'(STUFF_BITS_N));
    assign idx_inc   = idx_reg + 3'd1;

    // End of bit 7, or of the stuff bit that follows it.
    assign handoff = (state_reg == DATA) && bit_end && !stuff_due && (idx_reg == 3'd7);

    // The handshake pulses must coincide with the cycle the byte is taken,
    // so they are decoded from registered state and the live tx_valid.
    assign tx_ready    = !rst && (((state_reg == IDLE) && tx_valid) ||
                                  (handoff && !last_reg && tx_valid));
    assign tx_underrun = !rst && handoff && !last_reg && !tx_valid;

    // Next data bit to put on the line and its NRZI/stuffing effects.
    always_comb begin
        data_bit = shift_reg[idx_inc];
        if (state_reg == SYNC) begin
            data_bit = shift_reg[0];
        end else if (handoff) begin
            data_bit = tx_data[0];
        end
        next_level = data_bit ? level_reg : ~level_reg;
        ones_next  = data_bit ? (ones_reg + OW'(1)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            last_reg  <= 1'b0;
            ones_reg  <= '0;
            level_reg <= 1'b1;
            tx_oe     <= 1'b0;
            busy      <= 1'b0;
            dp_tx     <= 1'b1;
            dn_tx     <= 1'b0;
        end else begin
            if (state_reg == IDLE || bit_end) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (tx_valid) begin
                        shift_reg <= tx_data;
                        last_reg  <= tx_last;
                        idx_reg   <= '0;
                        // SYNC trailing 1 leaves the ones counter at 1
                        ones_reg  <= OW'(1);
                        level_reg <= 1'b0;
                        dp_tx     <= 1'b0;
                        dn_tx     <= 1'b1;
                        tx_oe     <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= SYNC;
                    end
                end

                SYNC: begin
                    if (bit_end) begin
                        if (idx_reg == 3'd7) begin
                            idx_reg   <= '0;
                            level_reg <= next_level;
                            dp_tx     <= next_level;
                            dn_tx     <= ~next_level;
                            ones_reg  <= ones_next;
                            state_reg <= DATA;
                        end else begin
                            // SYNC is 0x80: only the final bit holds the line
                            idx_reg   <= idx_inc;
                            level_reg <= (idx_reg == 3'd6) ? level_reg : ~level_reg;
                            dp_tx     <= (idx_reg == 3'd6) ? level_reg : ~level_reg;
                            dn_tx     <= (idx_reg == 3'd6) ? ~level_reg : level_reg;
                        end
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (stuff_due) begin
                            level_reg <= ~level_reg;
                            dp_tx     <= ~level_reg;
                            dn_tx     <= level_reg;
                            ones_reg  <= '0;
                        end else if (idx_reg == 3'd7) begin
                            if (last_reg || !tx_valid) begin
                                idx_reg   <= '0;
                                dp_tx     <= 1'b0;
                                dn_tx     <= 1'b0;
                                state_reg <= EOP_SE0;
                            end else begin
                                shift_reg <= tx_data;
                                last_reg  <= tx_last;
                                idx_reg   <= '0;
                                level_reg <= next_level;
                                dp_tx     <= next_level;
                                dn_tx     <= ~next_level;
                                ones_reg  <= ones_next;
                            end
                        end else begin
                            idx_reg   <= idx_inc;
                            level_reg <= next_level;
                            dp_tx     <= next_level;
                            dn_tx     <= ~next_level;
                            ones_reg  <= ones_next;
                        end
                    end
                end

                EOP_SE0: begin
                    if (bit_end) begin
                        if (idx_reg == 3'd0) begin
                            idx_reg <= 3'd1;
                        end else begin
                            dp_tx     <= 1'b1;
                            dn_tx     <= 1'b0;
                            state_reg <= EOP_J;
                        end
                    end
                end

                EOP_J: begin
                    if (bit_end) begin
                        tx_oe     <= 1'b0;
                        busy      <= 1'b0;
                        level_reg <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
